// File: rtl/load_store_unit.sv
// RV32I load/store unit: converts byte/half/word accesses into word-aligned memory
// operations, with read-modify-write for sub-word stores and extended load data.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmw, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [15:0] store_data_q;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic        accept;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state_q == StIdle) && req_valid;

  // Illegal funct3 for the direction, or natural misalignment.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:         req_err = 1'b0;
      3'b001:         req_err = req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      3'b100, 3'b101: req_err = req_is_store | (req_funct3[0] & req_addr[0]);
      default:        req_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_q[1:0])
      2'b00: byte_sel = mem_read_data[7:0];
      2'b01: byte_sel = mem_read_data[15:8];
      2'b10: byte_sel = mem_read_data[23:16];
      2'b11: byte_sel = mem_read_data[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  end

  // funct3[2] marks the zero-extending variants.
  always_comb begin
    load_val = mem_read_data;
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
      default: load_val = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = store_data_q;
      else           merged[15:0]  = store_data_q;
    end else begin
      unique case (addr_q[1:0])
        2'b00: merged[7:0]   = store_data_q[7:0];
        2'b01: merged[15:8]  = store_data_q[7:0];
        2'b10: merged[23:16] = store_data_q[7:0];
        2'b11: merged[31:24] = store_data_q[7:0];
        default: merged = mem_read_data;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    wbuf_d         = wbuf_q;
    resp_data_d    = resp_data_q;
    resp_error_d   = resp_error_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 32'h0;
    mem_write_data = 32'h0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          resp_data_d  = 32'h0;
          resp_error_d = req_err;
          if (req_err) begin
            state_d = StDone;
          end else if (!req_is_store) begin
            state_d = StLoad;
          end else if (req_funct3 == 3'b010) begin
            wbuf_d  = req_store_data;
            state_d = StWrite;
          end else begin
            state_d = StRmw;
          end
        end
      end
      StLoad: begin
        mem_read    = 1'b1;
        mem_address = {addr_q[31:2], 2'b00};
        resp_data_d = load_val;
        state_d     = StDone;
      end
      StRmw: begin
        mem_read    = 1'b1;
        mem_address = {addr_q[31:2], 2'b00};
        wbuf_d      = merged;
        state_d     = StWrite;
      end
      StWrite: begin
        mem_write      = 1'b1;
        mem_address    = {addr_q[31:2], 2'b00};
        mem_write_data = wbuf_q;
        state_d        = StDone;
      end
      StDone: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 16'h0;
      wbuf_q       <= 32'h0;
      resp_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wbuf_q       <= wbuf_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      if (accept) begin
        funct3_q     <= req_funct3;
        addr_q       <= req_addr;
        store_data_q <= req_store_data[15:0];
      end
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner cases and
// randomized traffic against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem       [0:63];
  logic [31:0] model_mem [0:63];

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_store_data (req_store_data),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write committed at the rising edge.
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:2]] = mem_write_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word-array memory, extension and lane merging by plain arithmetic.
  function automatic void model_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] d, output logic [31:0] rd,
                                   output logic er, output int lat, output logic [31:0] nw);
    int unsigned off = a[1:0];
    logic [31:0] w = model_mem[a[7:2]];
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] mask;
    rd = 32'h0;
    nw = w;
    if (st) er = !(f3 == 0 || (f3 == 1 && a[0] == 0) || (f3 == 2 && a[1:0] == 0));
    else    er = !(f3 == 0 || f3 == 4 || ((f3 == 1 || f3 == 5) && a[0] == 0) ||
                   (f3 == 2 && a[1:0] == 0));
    if (er) begin
      lat = 1;
    end else if (!st) begin
      lat = 2;
      b = 8'(w >> (8 * off));
      h = 16'(w >> (8 * off));
      case (f3)
        3'd0:    rd = 32'($signed(b));
        3'd4:    rd = {24'h0, b};
        3'd1:    rd = 32'($signed(h));
        3'd5:    rd = {16'h0, h};
        default: rd = w;
      endcase
    end else begin
      lat  = (f3 == 2) ? 2 : 3;
      mask = (f3 == 2) ? 32'hFFFF_FFFF : (f3 == 1) ? (32'hFFFF << (8 * off))
                                                  : (32'hFF << (8 * off));
      nw = (w & ~mask) | ((d << (8 * off)) & mask);
      model_mem[a[7:2]] = nw;
    end
  endfunction

  // One handshake; expectations from the table when use_tbl, otherwise from the model.
  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic use_tbl, input logic [31:0] t_data,
                     input logic t_err, input int t_lat);
    logic [31:0] m_data, m_word, e_data, wd;
    logic        m_err, e_err, got_err;
    logic [31:0] got_data;
    int          m_lat, e_lat, got_lat, rd_cyc, wr_cyc, bad_addr, both;
    model_op(st, f3, a, d, m_data, m_err, m_lat, m_word);
    e_data = use_tbl ? t_data : m_data;
    e_err  = use_tbl ? t_err : m_err;
    e_lat  = use_tbl ? t_lat : m_lat;
    got_lat = 0; got_data = 32'h0; got_err = 1'b0;
    rd_cyc = 0; wr_cyc = 0; bad_addr = 0; both = 0; wd = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_store_data = d;
    check("ready_before_req", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read) rd_cyc++;
      if (mem_write) begin wr_cyc++; wd = mem_write_data; end
      if (mem_read && mem_write) both++;
      if ((mem_read || mem_write) && mem_address !== {a[31:2], 2'b00}) bad_addr++;
      if (resp_valid) begin
        got_lat = k; got_data = resp_data; got_err = resp_error;
        break;
      end
    end
    check("resp_latency", got_lat, e_lat);
    check("resp_data", got_data, e_data);
    check("resp_error", {31'h0, got_err}, {31'h0, e_err});
    check("mem_read_cycles", rd_cyc, (!e_err && (!st || f3 != 2)) ? 1 : 0);
    check("mem_write_cycles", wr_cyc, (!e_err && st) ? 1 : 0);
    check("mem_addr_and_excl", bad_addr + both, 0);
    if (st && !e_err) check("mem_write_data", wd, m_word);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        preload;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input logic pre, input logic [31:0] ed,
                              input logic ee, input int el);
    vec_t v;
    v = '{st, f3, a, d, pre, ed, ee, el};
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] p_data, p_word, hd;
    logic        p_err, p_valid, hst;
    logic [2:0]  hf3;
    logic [31:0] ha;
    int          p_lat, acc, resps, bad, drain_left;
    logic        leak;

    for (int i = 0; i < 64; i++) begin mem[i] = 32'h0; model_mem[i] = 32'h0; end
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_store_data = 32'h0;

    // Reset values.
    @(negedge clk); @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_error", {31'h0, resp_error}, 32'd0);
    check("rst_mem_read", {31'h0, mem_read}, 32'd0);
    check("rst_mem_write", {31'h0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    rst = 1'b0;

    // Directed table: st, f3, addr, data, preload 0x8899AABB at 0x40, exp data/err/latency.
    add(0, 3'b000, 32'h41, 32'h0,        1, 32'hFFFF_FFAA, 0, 2);
    add(0, 3'b100, 32'h43, 32'h0,        0, 32'h0000_0088, 0, 2);
    add(0, 3'b001, 32'h42, 32'h0,        0, 32'hFFFF_8899, 0, 2);
    add(0, 3'b101, 32'h40, 32'h0,        0, 32'h0000_AABB, 0, 2);
    add(1, 3'b000, 32'h42, 32'hFFFF_FF5A, 0, 32'h0,        0, 3);
    add(0, 3'b010, 32'h40, 32'h0,        0, 32'h885A_AABB, 0, 2);
    add(1, 3'b001, 32'h40, 32'hABCD_1234, 1, 32'h0,        0, 3);
    add(0, 3'b010, 32'h40, 32'h0,        0, 32'h8899_1234, 0, 2);
    add(1, 3'b010, 32'h44, 32'hDEAD_BEEF, 0, 32'h0,        0, 2);
    add(0, 3'b010, 32'h44, 32'h0,        0, 32'hDEAD_BEEF, 0, 2);
    add(0, 3'b010, 32'h42, 32'h0,        0, 32'h0,        1, 1);
    add(1, 3'b001, 32'h41, 32'h0000_7777, 0, 32'h0,        1, 1);
    add(0, 3'b011, 32'h40, 32'h0,        0, 32'h0,        1, 1);
    add(1, 3'b100, 32'h44, 32'h0000_0055, 0, 32'h0,        1, 1);
    add(0, 3'b010, 32'h40, 32'h0,        0, 32'h8899_1234, 0, 2);
    add(1, 3'b000, 32'h47, 32'h0000_0011, 0, 32'h0,        0, 3);
    add(0, 3'b000, 32'h47, 32'h0,        0, 32'h0000_0011, 0, 2);
    add(0, 3'b101, 32'h46, 32'h0,        0, 32'h0000_11AD, 0, 2);
    foreach (vecs[i]) begin
      if (vecs[i].preload) begin mem[16] = 32'h8899_AABB; model_mem[16] = 32'h8899_AABB; end
      txn(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].data, 1'b1,
          vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Reset during the WRITE cycle of SW 0x11111111 to 0x48.
    mem[18] = 32'h2222_2222; model_mem[18] = 32'h2222_2222;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h48; req_store_data = 32'h1111_1111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_write", {31'h0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_write_drops", {31'h0, mem_write}, 32'd0);
    check("abort_ready_in_rst", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_hold", {31'h0, req_ready}, 32'd1);
    rst = 1'b0;
    leak = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) leak = 1'b1;
    end
    check("abort_no_resp", {31'h0, leak}, 32'd0);
    txn(0, 3'b010, 32'h48, 32'h0, 1'b1, 32'h2222_2222, 1'b0, 2);

    // Randomized single transactions against the model.
    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 32'h80 + $urandom_range(0, 15),
          $urandom, 1'b0, 32'h0, 1'b0, 0);
    end

    // req_valid held high with changing fields; only requests seen in IDLE are accepted.
    p_valid = 1'b0; p_data = 32'h0; p_err = 1'b0; acc = 0; resps = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (mem_read && mem_write) check("hold_excl", 32'd1, 32'd0);
      if (resp_valid) begin
        resps++;
        if (!p_valid) check("hold_spurious_resp", 32'd1, 32'd0);
        else begin
          check("hold_resp_data", resp_data, p_data);
          check("hold_resp_error", {31'h0, resp_error}, {31'h0, p_err});
          p_valid = 1'b0;
        end
      end
      hst = 1'($urandom_range(0, 1)); hf3 = 3'($urandom_range(0, 5));
      ha = 32'h80 + $urandom_range(0, 15); hd = $urandom;
      req_valid = 1'b1; req_is_store = hst; req_funct3 = hf3; req_addr = ha; req_store_data = hd;
      if (req_ready) begin
        model_op(hst, hf3, ha, hd, p_data, p_err, p_lat, p_word);
        p_valid = 1'b1;
        acc++;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain_left = p_valid ? 8 : 0;
    while (drain_left > 0) begin
      @(negedge clk);
      drain_left--;
      if (resp_valid) begin
        resps++;
        check("hold_resp_data", resp_data, p_data);
        check("hold_resp_error", {31'h0, resp_error}, {31'h0, p_err});
        drain_left = 0;
      end
    end
    check("hold_resp_count", resps, acc);

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== model_mem[i]) bad++;
    check("final_memory", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
